// File: rtl/tp_ram_pkg.sv
// Shared definitions for the two-port RAM with clear sweep: controller states
// and read-during-write mode selectors.
package tp_ram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/tp_ram_init.sv
// Clear sequencer: sweeps zero through every address after reset or on a clear
// request, and tells the array when normal accesses may be accepted.
module tp_ram_init
  import tp_ram_pkg::*;
#(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  output logic                 sweep_we_o,
  output logic [ADDRWIDTH-1:0] sweep_addr_o,
  output logic                 ready_o,
  output logic                 init_busy_o
);

  localparam logic [ADDRWIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;

  // State and sweep address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a clear arriving mid-sweep is deliberately not a restart
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_MAX) begin
          state_d = READY;
        end else begin
          state_d = INIT;
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    sweep_we_o  = 1'b0;
    ready_o     = 1'b0;
    init_busy_o = 1'b0;
    case (state_q)
      INIT: begin
        sweep_we_o  = 1'b1;
        init_busy_o = 1'b1;
      end
      READY: begin
        ready_o = 1'b1;
      end
      default: begin
        init_busy_o = 1'b1;
      end
    endcase
  end

  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/tp_ram.sv
// Simple dual-port RAM (one write, one read port) with byte-lane write enables,
// selectable read-during-write behaviour, optional output register and a
// whole-array clear sweep.
module tp_ram
  import tp_ram_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8,
  parameter int BYTEWIDTH = 8,
  parameter int OUT_REG   = 0,
  parameter int RDW_MODE  = 0,
  localparam int NBE      = DATAWIDTH / BYTEWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [NBE-1:0]       wbe,
  input  logic                 re,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid,
  output logic                 init_busy
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic                 sweep_we_s;
  logic [ADDRWIDTH-1:0] sweep_addr_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 wr_s;
  logic                 rd_s;
  logic [DATAWIDTH-1:0] merged_s;
  logic [DATAWIDTH-1:0] rd_word_s;
  logic [DATAWIDTH-1:0] rd1_q;
  logic                 rv1_q;

  function automatic logic [DATAWIDTH-1:0] lane_merge(
    input logic [DATAWIDTH-1:0] old_w,
    input logic [DATAWIDTH-1:0] new_w,
    input logic [NBE-1:0]       be
  );
    logic [DATAWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) begin
        res[i*BYTEWIDTH +: BYTEWIDTH] = new_w[i*BYTEWIDTH +: BYTEWIDTH];
      end
    end
    return res;
  endfunction

  tp_ram_init #(
    .ADDRWIDTH(ADDRWIDTH)
  ) u_init (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .sweep_we_o  (sweep_we_s),
    .sweep_addr_o(sweep_addr_s),
    .ready_o     (ready_s),
    .init_busy_o (init_busy)
  );

  // The cycle that requests a clear accepts no access of its own
  assign accept_s = ready_s & ~clr;
  assign wr_s     = accept_s & we;
  assign rd_s     = accept_s & re;
  assign merged_s = lane_merge(mem_q[waddr], wdata, wbe);

  // Array write port, shared between the clear sweep and user writes
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      mem_q[sweep_addr_s] <= '0;
    end else if (wr_s) begin
      mem_q[waddr] <= merged_s;
    end
  end

  // Read word selection including write-through for a same-address collision
  always_comb begin
    rd_word_s = mem_q[raddr];
    if ((RDW_MODE == RDW_NEW) && wr_s && (waddr == raddr)) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = mem_q[raddr];
    end
  end

  // First read stage; data holds whenever no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rv1_q <= rd_s;
      if (rd_s) begin
        rd1_q <= rd_word_s;
      end else begin
        rd1_q <= rd1_q;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATAWIDTH-1:0] rd2_q;
      logic                 rv2_q;

      // Optional output stage, advanced only by valid first-stage data
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_q <= '0;
          rv2_q <= 1'b0;
        end else begin
          rv2_q <= rv1_q;
          if (rv1_q) begin
            rd2_q <= rd1_q;
          end else begin
            rd2_q <= rd2_q;
          end
        end
      end

      assign rdata  = rd2_q;
      assign rvalid = rv2_q;
    end else begin : g_no_out_reg
      assign rdata  = rd1_q;
      assign rvalid = rv1_q;
    end
  endgenerate

endmodule

// File: doc/tp_ram.md
TP_RAM -- requirements
Module: tp_ram

Interface
REQ-001 SHALL provide parameter DATAWIDTH, default 8, data word width in bits (multiple of BYTEWIDTH).
REQ-002 SHALL provide parameter ADDRWIDTH, default 8, address width; depth = 2**ADDRWIDTH words.
REQ-003 SHALL provide parameter BYTEWIDTH, default 8, bits per byte-enable lane; NBE = DATAWIDTH/BYTEWIDTH.
REQ-004 SHALL provide parameter OUT_REG, default 0, adds one output register stage when 1.
REQ-005 SHALL provide parameter RDW_MODE, default 0, same-address read-during-write: 0 = old data, 1 = new (write-through) data.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clr  input  1  request to zero the whole array (one-cycle pulse).
REQ-009 we  input  1  write request.
REQ-010 waddr  input  ADDRWIDTH  write address.
REQ-011 wdata  input  DATAWIDTH  write data.
REQ-012 wbe  input  NBE  per-lane write enable; lane i covers wdata[i*BYTEWIDTH +: BYTEWIDTH].
REQ-013 re  input  1  read request.
REQ-014 raddr  input  ADDRWIDTH  read address.
REQ-015 rdata  output  DATAWIDTH  read data.
REQ-016 rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-017 init_busy  output  1  high while the array clear sweep runs.

Function
REQ-018 Controller SHALL have two states: INIT (clear sweep) and READY.
REQ-019 INIT SHALL write zero to address cnt each cycle, cnt 0..2**ADDRWIDTH-1, one address per cycle, all lanes.
REQ-020 After writing the last address, the FSM SHALL enter READY; init_busy SHALL be low from the following cycle; sweep length exactly 2**ADDRWIDTH cycles.
REQ-021 In READY, clr=1 SHALL enter INIT with cnt=0; clr during INIT SHALL be ignored (no restart).
REQ-022 In INIT, and in the READY cycle in which clr=1, we and re SHALL be ignored (no write, no rvalid).
REQ-023 In READY, we=1 SHALL update only lanes with wbe[i]=1; wbe=0 SHALL leave the word unchanged.
REQ-024 In READY, re=1 at edge T SHALL produce rvalid=1 and rdata at edge T+1 (OUT_REG=0) or T+2 (OUT_REG=1); back-to-back reads every cycle SHALL be supported.
REQ-025 rvalid SHALL be 0 in all cycles not matching REQ-024; rdata SHALL hold its last value when rvalid=0.
REQ-026 Simultaneous we and re, same address: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns pre-write word merged with enabled lanes of wdata.
REQ-027 Simultaneous we and re, different addresses SHALL proceed independently.
REQ-028 Reads accepted before a clr SHALL complete normally with pre-clear data.

Reset
REQ-029 rst_n=0 SHALL immediately force: rdata=0, rvalid=0, output pipeline valid=0, cnt=0, state=INIT, init_busy=1.
REQ-030 After rst_n rises, a full sweep (REQ-019/020) SHALL run before any access is accepted; reset mid-sweep SHALL restart from address 0.
REQ-031 The memory array itself SHALL NOT be reset directly; clearing is only via the sweep.

Structure
REQ-032 Package tp_ram_pkg SHALL hold the state encoding (INIT, READY) and RDW_MODE constants (RDW_OLD=0, RDW_NEW=1).
REQ-033 Clear sequencer (FSM + cnt + init_busy) SHALL be sub-module tp_ram_init; array, byte merge and read pipeline stay in tp_ram.

Verification
REQ-034 Release rst_n, defaults -> init_busy high exactly 256 cycles; then read addr 0x00 and 0xFF -> rdata 0x00 with rvalid at T+1.
REQ-035 DATAWIDTH=32: write 0xAABBCCDD wbe=4'hF addr 5, then 0x11223344 wbe=4'b0101 addr 5, read 5 -> 0xAA22CC44.
REQ-036 Same-cycle we/re addr 3, old 0x55, wdata 0x66, wbe all ones: RDW_MODE=0 -> 0x55, RDW_MODE=1 -> 0x66.
REQ-037 OUT_REG=1, reads addr 1,2,3 on consecutive cycles (data 0x01,0x02,0x03) -> rvalid high on T+2..T+4 with 0x01,0x02,0x03 in order.
REQ-038 Write 0x77 addr 9, pulse clr with re=1 -> no rvalid, init_busy 256 cycles, then read 9 -> 0x00.
REQ-039 Assert rst_n=0 at sweep cycle 100 -> outputs zero immediately; after release init_busy high a full 256 cycles again.
